// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers (E stage)
//
// Executes mult/multu/div/divu with a fixed, parametrised latency, plus the
// single-cycle mthi/mtlo moves. The arithmetic result is computed from the
// operands presented with start and held in a pending register. It is
// committed to HI/LO on the last busy cycle, so HI/LO keep their old values
// while busy=1.
//
// Request handshake: start is a one-cycle request sampled on a rising edge.
// It is accepted only when busy=0 and flush=0. There is no back-pressure.
// A request made while busy=1 is dropped, and the requester (the hazard unit)
// is expected to stall on (start | busy).
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-low
//   start      in   1      one-cycle request; op/inA/inB sampled with it
//   op         in   3      0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                          5 mthi, 6 mtlo, 7 none
//   inA        in   WIDTH  rs operand (dividend/multiplicand, mthi/mtlo data)
//   inB        in   WIDTH  rt operand (divisor/multiplier)
//   flush      in   1      abort in-flight operation; HI/LO are kept
//   busy       out  1      operation in flight
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
//   state_dbg  out  2      current FSM state (0 idle, 1 mult, 2 div)
// ---------------------------------------------------------------------------
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_we;

  // Arithmetic on the live operands; only used on the accept edge.
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   div_s_b;
  logic [WIDTH-1:0]   div_u_b;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quot_u;
  logic [WIDTH-1:0]   rem_u;

  always_comb begin
    prod_s   = $signed({{WIDTH{inA[WIDTH-1]}}, inA}) * $signed({{WIDTH{inB[WIDTH-1]}}, inB});
    prod_u   = {{WIDTH{1'b0}}, inA} * {{WIDTH{1'b0}}, inB};
    div_zero = (inB == '0);
    div_ovf  = (inA == {1'b1, {(WIDTH-1){1'b0}}}) && (inB == '1);
    // Substituting a divisor of 1 keeps the divider well defined. For
    // min / -1 this also gives exactly the required lo=min, hi=0. For a zero
    // divisor the result is never written (res_we=0).
    div_s_b  = (div_zero || div_ovf) ? WIDTH'(1) : inB;
    div_u_b  = div_zero ? WIDTH'(1) : inB;
    quot_s   = $signed(inA) / $signed(div_s_b);
    rem_s    = $signed(inA) % $signed(div_s_b);
    quot_u   = inA / div_u_b;
    rem_u    = inA % div_u_b;
  end

  assign state_dbg = state;

  // cnt is loaded with N on accept and counts down once per busy cycle.
  // Seeing cnt==1 marks the Nth busy edge, where the result commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_we <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (flush) begin
      // Flush discards any pending result, including one due on this edge,
      // and wins over a simultaneous start.
      state  <= ST_IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      res_we <= 1'b0;
    end else if (busy) begin
      if (cnt == CW'(1)) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        cnt    <= '0;
        res_we <= 1'b0;
        if (res_we) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          state  <= ST_MULT;
          busy   <= 1'b1;
          cnt    <= CW'(MULT_CYCLES);
          res_hi <= prod_s[2*WIDTH-1:WIDTH];
          res_lo <= prod_s[WIDTH-1:0];
          res_we <= 1'b1;
        end
        OP_MULTU: begin
          state  <= ST_MULT;
          busy   <= 1'b1;
          cnt    <= CW'(MULT_CYCLES);
          res_hi <= prod_u[2*WIDTH-1:WIDTH];
          res_lo <= prod_u[WIDTH-1:0];
          res_we <= 1'b1;
        end
        OP_DIV: begin
          state  <= ST_DIV;
          busy   <= 1'b1;
          cnt    <= CW'(DIV_CYCLES);
          res_hi <= rem_s;
          res_lo <= quot_s;
          res_we <= !div_zero;
        end
        OP_DIVU: begin
          state  <= ST_DIV;
          busy   <= 1'b1;
          cnt    <= CW'(DIV_CYCLES);
          res_hi <= rem_u;
          res_lo <= quot_u;
          res_we <= !div_zero;
        end
        OP_MTHI: hi <= inA;
        OP_MTLO: lo <= inA;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit -- directed and light random bench for md_unit.
// Expected HI/LO pairs are pushed to exp_q when an operation is issued and
// popped when the unit drops busy. m_hi/m_lo track the architectural HI/LO.
// ---------------------------------------------------------------------------
module tb_md_unit;

  localparam int W      = 32;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         flush;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   state_dbg;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;
  int             n_vec;
  int             n_err;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .inA       (in_a),
    .inB       (in_b),
    .flush     (flush),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- checking ----
  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- drivers (entered and left at #1 after a rising edge) ----
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    in_a  = a;
    in_b  = b;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Counts busy cycles; HI/LO must hold the old values while busy.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      check("hold_hilo", {hi, lo}, {m_hi, m_lo});
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic pop_and_check(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {hi, lo}, e);
      {m_hi, m_lo} = e;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] e, input int n);
    int cyc;
    exp_q.push_back(e);
    start_op(o, a, b);
    wait_idle(cyc);
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
    pop_and_check(tag);
  endtask

  task automatic do_mt(input string tag, input logic [2:0] o, input logic [W-1:0] a);
    start_op(o, a, '0);
    if (o == 3'd5) m_hi = a;
    else           m_lo = a;
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check(tag, {hi, lo}, {m_hi, m_lo});
  endtask

  // ---- stimulus ----
  initial begin
    int cyc;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] p;
    n_vec = 0;
    n_err = 0;
    m_hi  = '0;
    m_lo  = '0;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    in_a  = '0;
    in_b  = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // mult: -3 * 5 = -15
    do_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, MULT_N);
    // multu max * max
    do_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MULT_N);
    // divu 7/2 and div -7/2
    do_op("divu_7_2", 3'd4, 32'd7, 32'd2, {32'd1, 32'd3}, DIV_N);
    do_op("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, DIV_N);
    // div 7/-2: quotient -3, remainder +1 (sign of dividend)
    do_op("div_7_m2", 3'd3, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, DIV_N);
    // signed overflow min / -1
    do_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, DIV_N);

    // moves, then divide by zero must leave HI/LO untouched
    do_mt("mthi_11", 3'd5, 32'h11);
    do_mt("mtlo_22", 3'd6, 32'h22);
    do_op("div_zero", 3'd3, 32'd99, 32'd0, {32'h11, 32'h22}, DIV_N);
    do_op("divu_zero", 3'd4, 32'd99, 32'd0, {32'h11, 32'h22}, DIV_N);
    do_mt("mthi_abcd", 3'd5, 32'hABCD);

    // op 0 and 7 do nothing
    start_op(3'd7, 32'h5555, 32'h1);
    check("op7_busy", 64'(busy), 64'd0);
    check("op7_hilo", {hi, lo}, {m_hi, m_lo});
    start_op(3'd0, 32'h5555, 32'h1);
    check("op0_busy", 64'(busy), 64'd0);

    // mtlo while busy is ignored; the mult still completes
    exp_q.push_back({32'd0, 32'd12});
    start_op(3'd1, 32'd3, 32'd4);
    start_op(3'd6, 32'hDEAD, 32'd0);
    check("mtlo_busy_lo", {hi, lo}, {m_hi, m_lo});
    check("mtlo_busy_busy", 64'(busy), 64'd1);
    wait_idle(cyc);
    check("mtlo_busy_cycles", 64'(cyc), 64'(MULT_N - 1));
    pop_and_check("mtlo_busy_result");

    // flush on the 3rd busy cycle of a multu
    start_op(3'd2, 32'd1000, 32'd1000);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (MULT_N + 1) begin @(posedge clk); #1; end
    check("flush_no_late", {hi, lo}, {m_hi, m_lo});
    do_op("multu_after_flush", 3'd2, 32'd1000, 32'd1000, {32'd0, 32'd1000000}, MULT_N);

    // flush exactly on the completion edge discards the result
    start_op(3'd1, 32'd6, 32'd7);
    repeat (MULT_N - 1) begin @(posedge clk); #1; end
    check("flush_end_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_end_busy", 64'(busy), 64'd0);
    check("flush_end_hilo", {hi, lo}, {m_hi, m_lo});

    // flush together with start: start ignored
    flush = 1'b1;
    start_op(3'd5, 32'h7777, 32'd0);
    flush = 1'b0;
    check("flush_start_hilo", {hi, lo}, {m_hi, m_lo});
    start = 1'b1; op = 3'd1; in_a = 32'd2; in_b = 32'd2; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);

    // asynchronous reset during the 4th busy cycle of a div
    start_op(3'd3, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    check("rst_mid_busy_pre", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    do_op("div_after_rst", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_N);

    // a few random unsigned operations
    for (int i = 0; i < 4; i++) begin
      ra = $urandom();
      rb = $urandom_range(1, 100000);
      p  = 64'(ra) * 64'(rb);
      do_op("multu_rand", 3'd2, ra, rb, p, MULT_N);
      do_op("divu_rand", 3'd4, ra, rb, {ra % rb, ra / rb}, DIV_N);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
